// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared channel-FSM state encoding and default 10 MHz timing
//                constants for the button conditioning front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_press_chk = 2'd1;
    localparam logic [1:0] c_st_held      = 2'd2;
    localparam logic [1:0] c_st_rel_chk   = 2'd3;

    localparam int DEBOUNCE_CYCLES_10MHZ = 20000;
    localparam int REPEAT_DELAY_10MHZ    = 5000000;
    localparam int REPEAT_PERIOD_10MHZ   = 2000000;

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_ch
//  Description : One button channel: two-flop synchronizer, counter debouncer,
//                debounced level, press/release pulses and optional repeat.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_10MHZ,
    parameter int DB_W            = 16,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_10MHZ,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_10MHZ,
    parameter int RP_W            = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam logic [DB_W-1:0] c_db_last        = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] c_rp_delay_last  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] c_rp_period_last = RP_W'(REPEAT_PERIOD - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic [1:0]      r_state;
    logic [DB_W-1:0] r_db_cnt;
    logic [RP_W-1:0] r_rp_cnt;
    logic            r_rp_period;   // 0: waiting out first delay, 1: periodic phase
    logic            r_level;
    logic            r_press;
    logic            r_release;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_state     <= c_st_idle;
            r_db_cnt    <= '0;
            r_rp_cnt    <= '0;
            r_rp_period <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_sync1   <= i_btn_raw;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    r_db_cnt <= '0;
                    if (r_sync2) begin
                        r_state  <= c_st_press_chk;
                        r_db_cnt <= DB_W'(1);
                    end
                end

                c_st_press_chk: begin
                    if (!r_sync2) begin
                        r_state  <= c_st_idle;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == c_db_last) begin
                        r_state     <= c_st_held;
                        r_db_cnt    <= '0;
                        r_level     <= 1'b1;
                        r_press     <= 1'b1;
                        r_rp_cnt    <= '0;
                        r_rp_period <= 1'b0;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_W'(1);
                    end
                end

                c_st_held: begin
                    if (!r_sync2) begin
                        r_state  <= c_st_rel_chk;
                        r_db_cnt <= DB_W'(1);
                    end
                    // Repeat timing advances on every held cycle, including the
                    // one that starts a release check.
                    if (REPEAT_EN) begin
                        if (r_rp_cnt == (r_rp_period ? c_rp_period_last : c_rp_delay_last)) begin
                            r_press     <= 1'b1;
                            r_rp_cnt    <= '0;
                            r_rp_period <= 1'b1;
                        end else begin
                            r_rp_cnt <= r_rp_cnt + RP_W'(1);
                        end
                    end
                end

                c_st_rel_chk: begin
                    if (r_sync2) begin
                        r_state  <= c_st_held;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == c_db_last) begin
                        r_state   <= c_st_idle;
                        r_db_cnt  <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_W'(1);
                    end
                end

                default: begin
                    r_state  <= c_st_idle;
                    r_db_cnt <= '0;
                    r_level  <= 1'b0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule : btn_debounce_ch
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : btn_conditioner
//  Description : Per-button synchronize/debounce/pulse front end feeding the
//                animation and speed controls; channels are independent.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int               N_BTN           = 4,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_10MHZ,
    parameter int               DB_W            = 16,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 4'b1100,
    parameter int               REPEAT_DELAY    = REPEAT_DELAY_10MHZ,
    parameter int               REPEAT_PERIOD   = REPEAT_PERIOD_10MHZ,
    parameter int               RP_W            = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DB_W            (DB_W),
            .REPEAT_EN       (REPEAT_MASK[i]),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .RP_W            (RP_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_btn_raw (btn_raw[i]),
            .o_level   (btn_level[i]),
            .o_press   (btn_press[i]),
            .o_release (btn_release[i])
        );
    end

endmodule : btn_conditioner
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_conditioner
//  Description : Scoreboard bench for btn_conditioner with short debounce and
//                repeat timing; pulses are matched against expected edge times.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

    localparam int N_BTN = 4;
    localparam int DC    = 4;
    localparam int RD    = 20;
    localparam int RPD   = 8;
    localparam int LAT   = DC + 2;   // edges from drive negedge to output edge

    typedef struct {
        int cyc;
        int ch;
        int rel;
    } ev_t;

    logic             clk;
    logic             reset;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    int  ecnt     = 0;
    int  n_checks = 0;
    int  n_fail   = 0;
    ev_t exp_q[$];

    btn_conditioner #(
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (DC),
        .DB_W            (8),
        .REPEAT_MASK     (4'b1100),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RPD),
        .RP_W            (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_ev(input int cyc, input int ch, input int rel);
        ev_t e;
        e.cyc = cyc;
        e.ch  = ch;
        e.rel = rel;
        exp_q.push_back(e);
    endtask

    // Numbers each rising edge and pops the scoreboard for every pulse seen.
    task automatic monitor();
        forever begin
            @(posedge clk);
            ecnt++;
            #1;
            for (int c = 0; c < N_BTN; c++) begin
                n_checks++;
                if (btn_press[c] && btn_release[c]) begin
                    n_fail++;
                    $display("FAIL overlap ch%0d edge %0d: press=1 release=1, required not both", c, ecnt);
                end
                for (int r = 0; r < 2; r++) begin
                    logic seen;
                    seen = (r == 1) ? btn_release[c] : btn_press[c];
                    if (seen) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_pulse: ch%0d rel=%0d at edge %0d, required no pulse", c, r, ecnt);
                        end else begin
                            ev_t e;
                            e = exp_q.pop_front();
                            if (e.cyc !== ecnt || e.ch !== c || e.rel !== r) begin
                                n_fail++;
                                $display("FAIL pulse_match: got ch%0d rel=%0d edge %0d, required ch%0d rel=%0d edge %0d",
                                         c, r, ecnt, e.ch, e.rel, e.cyc);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({btn_level, btn_press, btn_release} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 0", {btn_level, btn_press, btn_release});
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (btn_level !== '0) begin
            n_fail++;
            $display("FAIL idle_level: got %b, required 0", btn_level);
        end
    endtask

    task automatic test_clean_press();
        int n0;
        @(negedge clk);
        n0 = ecnt;
        btn_raw[0] = 1'b1;
        push_ev(n0 + LAT, 0, 0);
        repeat (LAT - 1) @(negedge clk);
        n_checks++;
        if (btn_level[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_level_early: got %b, required 0", btn_level[0]);
        end
        @(negedge clk);
        n_checks++;
        if (btn_level[0] !== 1'b1 || btn_press[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_level_rise: got level=%b press=%b, required 1 1", btn_level[0], btn_press[0]);
        end
        repeat (30 - LAT) @(negedge clk);
        btn_raw[0] = 1'b0;
        push_ev(ecnt + LAT, 0, 1);
        repeat (LAT + 4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || btn_level[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_done: pending=%0d level=%b, required 0 0", exp_q.size(), btn_level[0]);
            exp_q.delete();
        end
    endtask

    task automatic test_bounce();
        int n0;
        @(negedge clk);
        n0 = ecnt;
        for (int i = 0; i < 4; i++) begin
            btn_raw[1] = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        btn_raw[1] = 1'b1;
        push_ev(n0 + 8 + LAT, 1, 0);
        repeat (LAT - 1) @(negedge clk);
        n_checks++;
        if (btn_level[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_level_early: got %b, required 0", btn_level[1]);
        end
        repeat (15) @(negedge clk);
        btn_raw[1] = 1'b0;
        push_ev(ecnt + LAT, 1, 1);
        repeat (LAT + 4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bounce_pending: got %0d unseen pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_auto_repeat();
        int n0;
        @(negedge clk);
        n0 = ecnt;
        btn_raw[2] = 1'b1;
        push_ev(n0 + 6, 2, 0);
        push_ev(n0 + 26, 2, 0);
        push_ev(n0 + 34, 2, 0);
        push_ev(n0 + 42, 2, 0);
        push_ev(n0 + 50, 2, 0);
        push_ev(n0 + 58, 2, 0);
        repeat (60) @(negedge clk);
        btn_raw[2] = 1'b0;
        push_ev(n0 + 66, 2, 1);
        repeat (15) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL repeat_pending: got %0d unseen pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_release_glitch();
        int n0;
        @(negedge clk);
        n0 = ecnt;
        btn_raw[3] = 1'b1;
        push_ev(n0 + 6, 3, 0);
        push_ev(n0 + 26, 3, 0);
        repeat (30) @(negedge clk);
        btn_raw[3] = 1'b0;
        repeat (2) @(negedge clk);
        btn_raw[3] = 1'b1;
        // Two frozen cycles push the next repeat from +34 to +36.
        push_ev(n0 + 36, 3, 0);
        push_ev(n0 + 44, 3, 0);
        push_ev(n0 + 52, 3, 0);
        push_ev(n0 + 60, 3, 0);
        push_ev(n0 + 68, 3, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (btn_level[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL glitch_level edge %0d: got %b, required 1", ecnt, btn_level[3]);
            end
        end
        repeat (32) @(negedge clk);
        btn_raw[3] = 1'b0;
        push_ev(n0 + 76, 3, 1);
        repeat (15) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_pending: got %0d unseen pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_simultaneous();
        int n0;
        @(negedge clk);
        n0 = ecnt;
        btn_raw[1:0] = 2'b11;
        push_ev(n0 + LAT, 0, 0);
        push_ev(n0 + LAT, 1, 0);
        repeat (LAT) @(negedge clk);
        n_checks++;
        if (btn_press[1:0] !== 2'b11) begin
            n_fail++;
            $display("FAIL simul_press: got %b, required 11", btn_press[1:0]);
        end
        repeat (10 - LAT) @(negedge clk);
        btn_raw[1:0] = 2'b00;
        push_ev(ecnt + LAT, 0, 1);
        push_ev(ecnt + LAT, 1, 1);
        repeat (LAT + 4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL simul_pending: got %0d unseen pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_hold();
        int n0;
        int m;
        @(negedge clk);
        n0 = ecnt;
        btn_raw[2] = 1'b1;
        push_ev(n0 + LAT, 2, 0);
        repeat (12) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({btn_level, btn_press, btn_release} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %b, required 0", {btn_level, btn_press, btn_release});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({btn_level, btn_press, btn_release} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: got %b, required 0", {btn_level, btn_press, btn_release});
            end
        end
        reset = 1'b0;
        m = ecnt;
        push_ev(m + LAT, 2, 0);
        repeat (10) @(negedge clk);
        btn_raw[2] = 1'b0;
        push_ev(m + 10 + LAT, 2, 1);
        repeat (LAT + 6) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_pending: got %0d unseen pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_glitch();
        test_simultaneous();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_btn_conditioner
`default_nettype wire
